// File: rtl/checkers_row_in_pio.sv
// Avalon-MM parallel input port for one row of the checkers board.
// Each of the 32 input bits is synchronized, edge-detected and latched
// into a sticky edge-capture register that can raise a masked interrupt.
module checkers_row_in_pio #(
    parameter int          EDGE_TYPE      = 0,      // 0 = rising, 1 = falling, 2 = any edge
    parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [31:0] in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    // Register map word addresses; anything else reads as zero.
    typedef enum logic [2:0] {
        ADDR_DATA = 3'd0,
        ADDR_MASK = 3'd2,
        ADDR_EDGE = 3'd3
    } reg_addr_e;

    // Synchronizer chain and history flop.
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;
    logic [31:0] sync3_q, sync3_d;

    // Programmer-visible state.
    logic [31:0] irq_mask_q, irq_mask_d;
    logic [31:0] edge_capture_q, edge_capture_d;
    logic [31:0] readdata_q, readdata_d;

    // Decoded bus strobes and per-bit edge events.
    logic        wr_en;
    logic        mask_we;
    logic        edge_we;
    logic [31:0] edge_bits;
    logic [31:0] clear_bits;

    // Bus write decode: single-cycle, no wait states.
    always_comb begin
        wr_en   = chipselect & ~write_n;
        mask_we = wr_en && (address == ADDR_MASK);
        edge_we = wr_en && (address == ADDR_EDGE);
    end

    // Synchronizer shifts in_port through two flops, then keeps one cycle of history.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // Per-bit edge detection between the synchronized value and its history.
    always_comb begin
        // NOTE: every combinational output is given a default first so no path leaves it unassigned and a latch cannot be inferred.
        edge_bits = '0;
        if (EDGE_TYPE == 0) begin
            edge_bits = sync2_q & ~sync3_q;
        end else if (EDGE_TYPE == 1) begin
            edge_bits = ~sync2_q & sync3_q;
        end else begin
            edge_bits = sync2_q ^ sync3_q;
        end
    end

    // Mask register loads the full write word on a write to its address.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (mask_we) begin
            irq_mask_d = writedata;
        end
    end

    // Sticky edge capture: write-one-to-clear, with a new edge overriding a same-cycle clear.
    always_comb begin
        clear_bits     = edge_we ? writedata : 32'h0;
        edge_capture_d = (edge_capture_q & ~clear_bits) | edge_bits;
    end

    // Read mux is registered every cycle regardless of chipselect, giving a fixed one-cycle latency.
    always_comb begin
        readdata_d = 32'h0;
        case (address)
            ADDR_DATA: readdata_d = sync2_q;
            ADDR_MASK: readdata_d = irq_mask_q;
            ADDR_EDGE: readdata_d = edge_capture_q;
            default:   readdata_d = 32'h0;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: reset is asynchronous so the capture state and interrupt drop without a running clock.
            sync1_q        <= 32'h0;
            sync2_q        <= 32'h0;
            sync3_q        <= 32'h0;
            irq_mask_q     <= IRQ_MASK_RESET;
            edge_capture_q <= 32'h0;
            readdata_q     <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, which keeps the synchronizer a true shift chain.
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    // Outputs: registered read data and a level interrupt straight from registered state.
    always_comb begin
        readdata = readdata_q;
        irq      = |(edge_capture_q & irq_mask_q);
    end

endmodule

// File: doc/checkers_row_in_pio.md
CHECKERS_ROW_IN_PIO -- requirements
Module: checkers_row_in_pio

Interface
REQ-001 Parameter EDGE_TYPE, default 0, capture on 0=rising, 1=falling, 2=any edge of a synchronized input bit.
REQ-002 Parameter IRQ_MASK_RESET, default 32'h0, reset value of the interrupt-mask register.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port address  input  3  Avalon-MM slave word address.
REQ-006 Port chipselect  input  1  slave select.
REQ-007 Port write_n  input  1  active-low write strobe.
REQ-008 Port writedata  input  32  write data.
REQ-009 Port in_port  input  32  asynchronous row input from the board, one bit per square.
REQ-010 Port readdata  output  32  registered read data.
REQ-011 Port irq  output  1  level interrupt to the processor.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2), then one history flop (sync3); data value = sync2.
REQ-013 Edge detect per bit: rise = sync2 & ~sync3, fall = ~sync2 & sync3, any = sync2 ^ sync3, selected by EDGE_TYPE.
REQ-014 Minimum latency from in_port change to edgecapture bit set SHALL be 3 clk rising edges (2 synchronizer + 1 capture).
REQ-015 Register map: addr 0 data (RO), addr 2 interruptmask (RW), addr 3 edgecapture (RW1C); addresses 1, 4-7 SHALL read 0 and ignore writes.
REQ-016 Write strobe = chipselect & ~write_n; no wait states; a write takes effect at the next clk rising edge.
REQ-017 Write to addr 0 SHALL have no effect.
REQ-018 Write to addr 2 SHALL load interruptmask with writedata[31:0].
REQ-019 Write to addr 3 SHALL clear each edgecapture bit whose writedata bit is 1; bits written 0 unchanged.
REQ-020 Edgecapture bit, once set, SHALL stay set until cleared by a write or reset (sticky).
REQ-021 Same-cycle clear and new edge on the same bit: set SHALL win; bit remains 1.
REQ-022 readdata SHALL register every cycle the mux of address (independent of chipselect/read): read latency exactly 1 cycle.
REQ-023 Read of addr 3 SHALL return edgecapture before any same-cycle clear takes effect (reads do not clear).
REQ-024 irq SHALL equal |(edgecapture & interruptmask), combinationally from registered state (no extra delay).
REQ-025 Mask change SHALL NOT alter edgecapture; unmasking a set bit asserts irq the cycle after the mask write.
REQ-026 Multiple edges on one bit before clear SHALL leave the bit at 1 (no counting, no overflow indication).

Reset
REQ-027 On reset_n low, immediately and asynchronously: sync1/sync2/sync3 = 0, edgecapture = 0, readdata = 0, interruptmask = IRQ_MASK_RESET, irq = |(0 & mask) = 0.
REQ-028 Reset mid-operation SHALL discard pending edges; after release, in_port already high with EDGE_TYPE=0 SHALL produce exactly one capture (0->1 through synchronizer).
REQ-029 Reset deassertion is synchronized externally; block SHALL NOT require a specific release cycle.

Verification
REQ-030 EDGE_TYPE=0, in_port 0 -> 32'h0000_0010 held: edgecapture reads 32'h10 from 3rd edge onward; irq stays 0 with mask 0.
REQ-031 Write mask 32'h10 to addr 2 with edgecapture=32'h10 -> irq = 1 next cycle; write 32'h10 to addr 3 -> edgecapture 0, irq 0 next cycle.
REQ-032 Bit 4 clear write coinciding with a new rising edge on bit 4 -> edgecapture bit 4 remains 1, irq stays 1.
REQ-033 Read addr 0 with in_port = 32'hA5A5_0F0F stable >3 cycles -> readdata 32'hA5A5_0F0F one cycle after address presented; addr 5 -> 0.
REQ-034 EDGE_TYPE=2, bit 0 pulses 0->1->0 (each level held 4 cycles) -> bit 0 set after rise, stays set through fall; EDGE_TYPE=1 sets only on fall.
REQ-035 Assert reset_n low mid-capture with edgecapture=32'hFF, mask=32'hFF -> edgecapture 0, irq 0, mask = IRQ_MASK_RESET without waiting for clk.
